// File: rtl/bs_4_demux14_deser.sv
// Registered 1:4 lane demultiplexer / deserializer with valid/ready handoff.
// Beats are steered into one of four lane registers, either by {s0,s1} or by an
// internal wrapping pointer; once all four lanes are valid the word is offered
// on Y0..Y3 with out_valid until the consumer takes it.
module bs_4_demux14_deser #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic         s0,
    input  logic         s1,
    output logic [W-1:0] Y0,
    output logic [W-1:0] Y1,
    output logic [W-1:0] Y2,
    output logic [W-1:0] Y3,
    output logic [3:0]   lane_vld,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         ovw
);

    typedef enum logic {StFill, StFull} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] y_q [4];
    logic [3:0]   vld_q, vld_d;
    logic [1:0]   ptr_q, ptr_d;
    logic         ovw_q, ovw_d;

    logic         accept;
    logic [1:0]   lane;
    logic [3:0]   lane_oh;

    assign in_ready  = (state_q == StFill) ? 1'b1 : out_ready;
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == StFull);
    assign lane_vld  = vld_q;
    assign ovw       = ovw_q;
    assign Y0        = y_q[0];
    assign Y1        = y_q[1];
    assign Y2        = y_q[2];
    assign Y3        = y_q[3];

    // Lane selection; an accept in FULL starts a new frame, so the pointer reads as 0.
    always_comb begin
        lane = {s0, s1};
        if (mode) begin
            lane = (state_q == StFull) ? 2'd0 : ptr_q;
        end
        lane_oh = 4'b0001 << lane;
    end

    // Next-state for FSM, lane-valid mask, write pointer and overwrite pulse.
    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        ptr_d   = ptr_q;
        ovw_d   = 1'b0;
        unique case (state_q)
            StFill: begin
                if (accept) begin
                    vld_d = vld_q | lane_oh;
                    ovw_d = |(vld_q & lane_oh);
                    if (mode) begin
                        ptr_d = ptr_q + 2'd1;
                    end
                    if (vld_d == 4'b1111) begin
                        state_d = StFull;
                    end
                end
            end
            StFull: begin
                if (out_ready) begin
                    state_d = StFill;
                    if (accept) begin
                        vld_d = lane_oh;
                        ptr_d = mode ? 2'd1 : 2'd0;
                    end else begin
                        vld_d = 4'b0000;
                        ptr_d = 2'd0;
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    // State and lane data registers; data is only ever cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFill;
            vld_q   <= 4'b0000;
            ptr_q   <= 2'd0;
            ovw_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                y_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            ptr_q   <= ptr_d;
            ovw_q   <= ovw_d;
            if (accept) begin
                y_q[lane] <= din;
            end
        end
    end

endmodule

// File: tb/tb_bs_4_demux14_deser.sv
// Directed self-checking bench for bs_4_demux14_deser.
module tb_bs_4_demux14_deser;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    logic       in_valid;
    logic       in_ready;
    logic       mode;
    logic       s0;
    logic       s1;
    logic [3:0] Y0, Y1, Y2, Y3;
    logic [3:0] lane_vld;
    logic       out_valid;
    logic       out_ready;
    logic       ovw;

    int checks = 0;
    int errors = 0;

    bs_4_demux14_deser #(.W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .s0        (s0),
        .s1        (s1),
        .Y0        (Y0),
        .Y1        (Y1),
        .Y2        (Y2),
        .Y3        (Y3),
        .lane_vld  (lane_vld),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovw       (ovw)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_y(input string tag, input logic [15:0] exp);
        chk(tag, {16'h0, Y3, Y2, Y1, Y0}, {16'h0, exp});
    endtask

    initial begin
        rst = 1'b1; din = 4'h0; in_valid = 1'b0; mode = 1'b0;
        s0 = 1'b0; s1 = 1'b0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk_y("rst_y", 16'h0000);
        chk("rst_vld", lane_vld, 4'b0000);
        chk("rst_ov", out_valid, 1'b0);
        chk("rst_ovw", ovw, 1'b0);
        chk("rst_rdy", in_ready, 1'b1);

        // Reset mid-frame
        mode = 1'b1; in_valid = 1'b1;
        din = 4'hA; step();
        din = 4'hB; step();
        chk_y("mid_y", 16'h00BA);
        chk("mid_vld", lane_vld, 4'b0011);
        rst = 1'b1; in_valid = 1'b0; step();
        rst = 1'b0;
        chk_y("mid_rst_y", 16'h0000);
        chk("mid_rst_vld", lane_vld, 4'b0000);
        chk("mid_rst_ov", out_valid, 1'b0);

        // Sequential fill
        in_valid = 1'b1;
        din = 4'h1; step();
        chk_y("seq_b1", 16'h0001);
        chk("seq_b1_vld", lane_vld, 4'b0001);
        din = 4'h2; step();
        din = 4'h3; step();
        chk("seq_b3_ov", out_valid, 1'b0);
        din = 4'h4; step();
        chk_y("seq_y", 16'h4321);
        chk("seq_ov", out_valid, 1'b1);
        chk("seq_rdy", in_ready, 1'b0);
        din = 4'hF;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_y("seq_hold_y", 16'h4321);
            chk("seq_hold_ov", out_valid, 1'b1);
            chk("seq_hold_vld", lane_vld, 4'b1111);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("full_rdy_comb", in_ready, 1'b1);
        step();
        chk("hand_ov", out_valid, 1'b0);
        chk("hand_vld", lane_vld, 4'b0000);
        chk_y("hand_keep_y", 16'h4321);
        out_ready = 1'b0;

        // Addressed fill, out of order
        mode = 1'b0; in_valid = 1'b1;
        s0 = 1'b1; s1 = 1'b1; din = 4'hD; step();
        chk("adr_b1_vld", lane_vld, 4'b1000);
        s0 = 1'b0; s1 = 1'b0; din = 4'h5; step();
        s0 = 1'b1; s1 = 1'b0; din = 4'h9; step();
        chk("adr_b3_ov", out_valid, 1'b0);
        chk("adr_b3_vld", lane_vld, 4'b1101);
        s0 = 1'b0; s1 = 1'b1; din = 4'h7; step();
        chk_y("adr_y", 16'hD975);
        chk("adr_ov", out_valid, 1'b1);
        chk("adr_ovw", ovw, 1'b0);

        // Back-to-back frames: handoff with simultaneous sequential accept
        out_ready = 1'b1; mode = 1'b1; din = 4'h6; step();
        chk("b2b_ov", out_valid, 1'b0);
        chk("b2b_vld", lane_vld, 4'b0001);
        chk_y("b2b_y", 16'hD976);
        din = 4'h7; step();
        din = 4'h8; step();
        chk("b2b_b3_ov", out_valid, 1'b0);
        din = 4'h9; step();
        chk_y("b2b_y2", 16'h9876);
        chk("b2b_ov2", out_valid, 1'b1);

        // Drain, then wrap test with out_ready held
        in_valid = 1'b0; step();
        chk("drain_ov", out_valid, 1'b0);
        in_valid = 1'b1;
        din = 4'h1; step();
        din = 4'h2; step();
        din = 4'h3; step();
        chk("wrap_b3_ov", out_valid, 1'b0);
        din = 4'h4; step();
        chk("wrap_b4_ov", out_valid, 1'b1);
        chk_y("wrap_y4", 16'h4321);
        din = 4'h5; step();
        chk("wrap_b5_ov", out_valid, 1'b0);
        chk("wrap_b5_vld", lane_vld, 4'b0001);
        chk_y("wrap_y5", 16'h4325);
        din = 4'h6; step();
        chk("wrap_b6_ov", out_valid, 1'b0);
        chk("wrap_b6_vld", lane_vld, 4'b0011);
        chk_y("wrap_y6", 16'h4365);

        // Overwrite in addressed mode
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1; step();
        rst = 1'b0;
        mode = 1'b0; s0 = 1'b1; s1 = 1'b0; in_valid = 1'b1;
        din = 4'h3; step();
        chk("ow_b1_ovw", ovw, 1'b0);
        chk("ow_b1_vld", lane_vld, 4'b0100);
        din = 4'hE; step();
        chk("ow_y2", Y2, 4'hE);
        chk("ow_ovw", ovw, 1'b1);
        chk("ow_vld", lane_vld, 4'b0100);
        chk("ow_ov", out_valid, 1'b0);
        in_valid = 1'b0; step();
        chk("ow_ovw_end", ovw, 1'b0);
        chk("ow_y2_hold", Y2, 4'hE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
